// File: rtl/clk_div_multi.sv
// clk_div_multi
//   Multi-channel, run-time programmable clock divider / tick generator.
//   Each channel toggles a 50 % duty square wave every max(half,1) enabled
//   cycles and raises a one-cycle Tick in the first cycle the new level is
//   visible. Half-period registers are reloaded through a shared write port.
//
// Ports
//   Clock     in   system clock, all logic on the rising edge
//   Reset     in   synchronous, active-high reset (all channels)
//   Enable    in   [NUM_CH]  per-channel run enable
//   WrEn      in   half-period write strobe
//   WrAddr    in   [ADDR_W]  channel index for the write (>= NUM_CH ignored)
//   WrData    in   [CNT_W]   new half-period in Clock cycles
//   newClock  out  [NUM_CH]  divided square wave, registered
//   Tick      out  [NUM_CH]  one-cycle strobe at each newClock toggle, registered
module clk_div_multi #(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 16,
  parameter int ADDR_W   = 2,
  parameter int DEF_HALF = 13500
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [NUM_CH-1:0] Enable,
  input  logic              WrEn,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [CNT_W-1:0]  WrData,
  output logic [NUM_CH-1:0] newClock,
  output logic [NUM_CH-1:0] Tick
);

  logic [CNT_W-1:0]  cnt  [NUM_CH];
  logic [CNT_W-1:0]  half [NUM_CH];
  logic [NUM_CH-1:0] wr_hit;

  // A half-period of 0 is treated as 1, so the terminal count never
  // underflows and cnt stays at most 2^CNT_W - 2.
  function automatic logic [CNT_W-1:0] term_of(input logic [CNT_W-1:0] h);
    return (h == '0) ? '0 : h - CNT_W'(1);
  endfunction

  // Write decode; addresses at or above NUM_CH match no channel and are dropped.
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_hit[i] = WrEn && (32'(WrAddr) == 32'(i));
    end
  end

  // Single register stage: counters, half-period registers and outputs.
  // A write takes priority over counting so a reload that coincides with
  // the terminal count suppresses that toggle.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i]  <= '0;
        half[i] <= CNT_W'(DEF_HALF);
      end
      newClock <= '0;
      Tick     <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_hit[i]) begin
          half[i] <= WrData;
          cnt[i]  <= '0;
          Tick[i] <= 1'b0;
        end else if (Enable[i]) begin
          if (cnt[i] == term_of(half[i])) begin
            cnt[i]      <= '0;
            newClock[i] <= ~newClock[i];
            Tick[i]     <= 1'b1;
          end else begin
            cnt[i]  <= cnt[i] + CNT_W'(1);
            Tick[i] <= 1'b0;
          end
        end else begin
          Tick[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_div_multi.sv
module tb_clk_div_multi;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Main build: NUM_CH=4, DEF_HALF=5
  logic        Reset = 1'b1;
  logic [3:0]  Enable = 4'h0;
  logic        WrEn = 1'b0;
  logic [1:0]  WrAddr = 2'd0;
  logic [15:0] WrData = 16'd0;
  logic [3:0]  newClock, Tick;

  clk_div_multi #(.NUM_CH(4), .CNT_W(16), .ADDR_W(2), .DEF_HALF(5)) dut (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .WrEn(WrEn),
    .WrAddr(WrAddr), .WrData(WrData), .newClock(newClock), .Tick(Tick));

  // Second build: NUM_CH=3, address 3 is out of range
  logic        rst3 = 1'b1;
  logic [2:0]  en3 = 3'h0;
  logic        wr3 = 1'b0;
  logic [1:0]  addr3 = 2'd0;
  logic [15:0] data3 = 16'd0;
  logic [2:0]  clk3, tick3;

  clk_div_multi #(.NUM_CH(3), .CNT_W(16), .ADDR_W(2), .DEF_HALF(5)) dut3 (
    .Clock(Clock), .Reset(rst3), .Enable(en3), .WrEn(wr3),
    .WrAddr(addr3), .WrData(data3), .newClock(clk3), .Tick(tick3));

  // Wide build: default parameters (DEF_HALF=13500)
  logic        rstw = 1'b1;
  logic [3:0]  enw = 4'h0;
  logic        wrw = 1'b0;
  logic [1:0]  addrw = 2'd0;
  logic [15:0] dataw = 16'd0;
  logic [3:0]  clkw, tickw;

  clk_div_multi dutw (
    .Clock(Clock), .Reset(rstw), .Enable(enw), .WrEn(wrw),
    .WrAddr(addrw), .WrData(dataw), .newClock(clkw), .Tick(tickw));

  typedef struct {
    logic        rst;
    logic [3:0]  en;
    logic        wr;
    logic [1:0]  addr;
    logic [15:0] data;
    int          ncyc;
    logic [3:0]  mask;
    logic [3:0]  exp_clk;
    logic [3:0]  exp_tick;
  } vec_t;

  vec_t vecs[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial begin
    int tog[$];
    logic prev;

    //                rst en     wr   addr  data   n  mask   clk      tick
    // reset, release, first toggles at edge 5 and 10
    vecs.push_back('{1'b1, 4'hF, 1'b0, 2'd0, 16'd0, 3, 4'hF, 4'b0000, 4'b0000}); // 0
    vecs.push_back('{1'b0, 4'hF, 1'b0, 2'd0, 16'd0, 4, 4'hF, 4'b0000, 4'b0000}); // 1  e4
    vecs.push_back('{1'b0, 4'hF, 1'b0, 2'd0, 16'd0, 1, 4'hF, 4'b1111, 4'b1111}); // 2  e5
    vecs.push_back('{1'b0, 4'hF, 1'b0, 2'd0, 16'd0, 1, 4'hF, 4'b1111, 4'b0000}); // 3  e6
    vecs.push_back('{1'b0, 4'hF, 1'b0, 2'd0, 16'd0, 4, 4'hF, 4'b0000, 4'b1111}); // 4  e10
    // ch1 half=2, ch2 half=0
    vecs.push_back('{1'b0, 4'hF, 1'b1, 2'd1, 16'd2, 1, 4'hF, 4'b0000, 4'b0000}); // 5  e11
    vecs.push_back('{1'b0, 4'hF, 1'b1, 2'd2, 16'd0, 1, 4'hF, 4'b0000, 4'b0000}); // 6  e12
    vecs.push_back('{1'b0, 4'hF, 1'b0, 2'd0, 16'd0, 1, 4'hF, 4'b0110, 4'b0110}); // 7  e13
    vecs.push_back('{1'b0, 4'hF, 1'b0, 2'd0, 16'd0, 1, 4'hF, 4'b0010, 4'b0100}); // 8  e14
    vecs.push_back('{1'b0, 4'hF, 1'b0, 2'd0, 16'd0, 1, 4'hF, 4'b1101, 4'b1111}); // 9  e15
    vecs.push_back('{1'b0, 4'hF, 1'b0, 2'd0, 16'd0, 1, 4'hF, 4'b1001, 4'b0100}); // 10 e16
    vecs.push_back('{1'b0, 4'hF, 1'b0, 2'd0, 16'd0, 1, 4'hF, 4'b1111, 4'b0110}); // 11 e17
    vecs.push_back('{1'b0, 4'hF, 1'b0, 2'd0, 16'd0, 7, 4'hF, 4'b0000, 4'b0100}); // 12 e24
    vecs.push_back('{1'b0, 4'hF, 1'b0, 2'd0, 16'd0, 1, 4'hF, 4'b1111, 4'b1111}); // 13 e25
    // enable gating on ch0 (cnt0=3 after e28)
    vecs.push_back('{1'b0, 4'hF, 1'b0, 2'd0, 16'd0, 3, 4'h1, 4'b0001, 4'b0000}); // 14 e28
    vecs.push_back('{1'b0, 4'hE, 1'b0, 2'd0, 16'd0, 1, 4'h1, 4'b0001, 4'b0000}); // 15 e29
    vecs.push_back('{1'b0, 4'hE, 1'b0, 2'd0, 16'd0, 1, 4'h1, 4'b0001, 4'b0000}); // 16 e30
    vecs.push_back('{1'b0, 4'hE, 1'b0, 2'd0, 16'd0, 5, 4'h1, 4'b0001, 4'b0000}); // 17 e35
    vecs.push_back('{1'b0, 4'hF, 1'b0, 2'd0, 16'd0, 1, 4'h1, 4'b0001, 4'b0000}); // 18 e36
    vecs.push_back('{1'b0, 4'hF, 1'b0, 2'd0, 16'd0, 1, 4'h1, 4'b0000, 4'b0001}); // 19 e37
    // write ch0=3 on the terminal-count cycle
    vecs.push_back('{1'b0, 4'hF, 1'b0, 2'd0, 16'd0, 4, 4'h1, 4'b0000, 4'b0000}); // 20 e41
    vecs.push_back('{1'b0, 4'hF, 1'b1, 2'd0, 16'd3, 1, 4'h1, 4'b0000, 4'b0000}); // 21 e42
    vecs.push_back('{1'b0, 4'hF, 1'b0, 2'd0, 16'd0, 2, 4'h1, 4'b0000, 4'b0000}); // 22 e44
    vecs.push_back('{1'b0, 4'hF, 1'b0, 2'd0, 16'd0, 1, 4'h1, 4'b0001, 4'b0001}); // 23 e45
    vecs.push_back('{1'b0, 4'hF, 1'b0, 2'd0, 16'd0, 2, 4'h1, 4'b0001, 4'b0000}); // 24 e47
    vecs.push_back('{1'b0, 4'hF, 1'b0, 2'd0, 16'd0, 1, 4'h1, 4'b0000, 4'b0001}); // 25 e48
    // build newClock=1010, then reset with a coincident write
    vecs.push_back('{1'b1, 4'hF, 1'b0, 2'd0, 16'd0, 2, 4'hF, 4'b0000, 4'b0000}); // 26
    vecs.push_back('{1'b0, 4'hF, 1'b0, 2'd0, 16'd0, 5, 4'hF, 4'b1111, 4'b1111}); // 27
    vecs.push_back('{1'b0, 4'h5, 1'b0, 2'd0, 16'd0, 6, 4'hF, 4'b1010, 4'b0000}); // 28
    vecs.push_back('{1'b1, 4'hF, 1'b1, 2'd1, 16'd9, 1, 4'hF, 4'b0000, 4'b0000}); // 29
    vecs.push_back('{1'b0, 4'hF, 1'b0, 2'd0, 16'd0, 4, 4'hF, 4'b0000, 4'b0000}); // 30
    vecs.push_back('{1'b0, 4'hF, 1'b0, 2'd0, 16'd0, 1, 4'hF, 4'b1111, 4'b1111}); // 31
    vecs.push_back('{1'b0, 4'hF, 1'b0, 2'd0, 16'd0, 5, 4'hF, 4'b0000, 4'b1111}); // 32

    @(negedge Clock);
    for (int v = 0; v < vecs.size(); v++) begin
      Reset  = vecs[v].rst;
      Enable = vecs[v].en;
      WrEn   = vecs[v].wr;
      WrAddr = vecs[v].addr;
      WrData = vecs[v].data;
      repeat (vecs[v].ncyc) @(posedge Clock);
      #1;
      chk($sformatf("vec%0d_newClock", v), newClock & vecs[v].mask, vecs[v].exp_clk);
      chk($sformatf("vec%0d_Tick", v), Tick & vecs[v].mask, vecs[v].exp_tick);
    end
    WrEn = 1'b0;

    // NUM_CH=3 build: write to address 3 must change nothing
    rst3 = 1'b1; en3 = 3'b111;
    repeat (2) @(posedge Clock);
    #1;
    rst3 = 1'b0; wr3 = 1'b1; addr3 = 2'd3; data3 = 16'd1;
    @(posedge Clock);
    #1;
    wr3 = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    chk("nch3_e4_newClock", {1'b0, clk3}, 4'b0000);
    chk("nch3_e4_Tick", {1'b0, tick3}, 4'b0000);
    @(posedge Clock);
    #1;
    chk("nch3_e5_newClock", {1'b0, clk3}, 4'b0111);
    chk("nch3_e5_Tick", {1'b0, tick3}, 4'b0111);

    // Wide count with default DEF_HALF
    rstw = 1'b1; enw = 4'hF;
    repeat (2) @(posedge Clock);
    #1;
    rstw = 1'b0;
    prev = clkw[0];
    for (int cyc = 1; cyc <= 60000; cyc++) begin
      @(posedge Clock);
      #1;
      if (clkw[0] !== prev) begin
        tog.push_back(cyc);
        chk($sformatf("wide_tick_at_%0d", cyc), {3'b000, tickw[0]}, 4'b0001);
        prev = clkw[0];
      end
    end
    chk_int("wide_toggle_count", tog.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < tog.size()) chk_int($sformatf("wide_toggle%0d", k), tog[k], 13500 * (k + 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
